muldiv_seq: RTL and testbench
=============================

Name: muldiv_seq

Overview:
- Iterative RV32M multiply/divide sequencer beside the shared integer ALU in the execute stage.
- Accepts one M-extension operation through a valid/ready request channel.
- Runs a 32-step shift-add multiply or restoring divide on operand magnitudes, applies the sign correction, then returns the result on a valid/ready response channel.
- Pipeline stalls on req_ready/busy and discards in-flight work with flush.

Parameters:
- XLEN, 32, operand/result width; only 32 is supported.
- TAG_W, 5, width of the opaque tag carried from request to response (destination register index).

Ports:
- clk  in  1  clock, all state rising-edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept; high only in IDLE.
- req_op  in  3  operation, funct3 encoding (see package).
- req_a  in  XLEN  rs1 value.
- req_b  in  XLEN  rs2 value.
- req_tag  in  TAG_W  tag, returned unchanged.
- flush  in  1  abort any in-flight operation.
- resp_valid  out  1  result available.
- resp_ready  in  1  consumer accepts result.
- resp_result  out  XLEN  result.
- resp_tag  out  TAG_W  tag of the result.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset (async, any state): state=IDLE, resp_valid=0, resp_result=0, resp_tag=0, busy=0, req_ready=1 (combinational from IDLE), counter=0.
- States: IDLE, BUSY, DONE.
- IDLE:
  - Accept on req_valid & req_ready (cycle T): latch op, tag, operand magnitudes and result-sign flags.
  - Special cases go to DONE at T+1 with the result set directly:
    - Divide by zero: DIV/DIVU quotient 0xFFFFFFFF; REM/REMU remainder = req_a.
    - DIV overflow (0x80000000 / 0xFFFFFFFF): quotient 0x80000000; REM remainder 0.
  - All other operations go to BUSY with counter=31.
- BUSY:
  - One iteration per cycle; counter decrements.
  - At counter==0 the final step completes, sign correction is applied, and the state becomes DONE.
  - resp_valid rises at T+33.
- Multiply:
  - 64-bit unsigned shift-add on magnitudes; result negated when the sign flag is set.
  - Signedness: MUL/MULH both signed; MULHSU a signed, b unsigned; MULHU both unsigned.
  - MUL returns product[31:0]; MULH/MULHSU/MULHU return product[63:32].
- Divide:
  - Restoring divide on magnitudes; DIV/REM signed, DIVU/REMU unsigned.
  - Quotient negated if the operand signs differ.
  - Remainder takes the sign of the dividend.
  - Quotient truncates toward zero.
- DONE:
  - resp_valid=1; resp_result and resp_tag held stable until resp_ready.
  - On resp_ready go to IDLE next cycle.
  - No new request is accepted in the same cycle (req_ready=0 in DONE).
- flush:
  - In BUSY or DONE, go to IDLE next cycle; resp_valid drops with no handshake.
  - In IDLE, a same-cycle request is not accepted: req_ready is masked by flush.
  - flush dominates resp_ready.
- req_valid while not IDLE is ignored; no queuing.
- Undefined behaviour is not permitted: every op code is legal; counter never underflows.

Decomposition:
- muldiv_pkg holds:
  - typedef enum logic [2:0] muldiv_op_e: MUL=0, MULH=1, MULHSU=2, MULHU=3, DIV=4, DIVU=5, REM=6, REMU=7.
  - typedef enum state_e: IDLE, BUSY, DONE.
  - Constants DIV_ZERO_Q=32'hFFFFFFFF, INT_MIN=32'h80000000.
- No sub-module. The per-step add/subtract and the final negation are inline combinational logic in one file.

Test Plan:
- MUL 7 × 0xFFFFFFFD (−3) -> resp_valid at T+33, result 0xFFFFFFEB, tag echoed.
- MULH 0x80000000 × 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9 (−7) / 2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 100 / 7 -> 14; REMU -> 2.
- Special cases, each with resp_valid at T+1:
  - DIVU 5 / 0 -> 0xFFFFFFFF; REMU 5 / 0 -> 5.
  - DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM same -> 0.
- Backpressure: resp_ready held low 10 cycles in DONE -> resp_result/resp_tag stable, req_ready=0, new req_valid ignored; resp_ready pulse -> IDLE next cycle.
- Abort and reset:
  - flush at T+10 of a DIV -> IDLE at T+11, no resp_valid; a new request at T+12 completes correctly.
  - rst asserted asynchronously mid-BUSY -> outputs reach reset values immediately.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative RV32M multiply/divide sequencer.
package muldiv_pkg;

  localparam int XLEN_C = 32;

  typedef enum logic [2:0] {
    MUL    = 3'd0,
    MULH   = 3'd1,
    MULHSU = 3'd2,
    MULHU  = 3'd3,
    DIV    = 3'd4,
    DIVU   = 3'd5,
    REM    = 3'd6,
    REMU   = 3'd7
  } muldiv_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [XLEN_C-1:0] DIV_ZERO_Q = 32'hFFFF_FFFF;
  localparam logic [XLEN_C-1:0] INT_MIN    = 32'h8000_0000;

endpackage

// File: rtl/muldiv_seq.sv
// Iterative RV32M sequencer: 32-step shift-add multiply / restoring divide on
// operand magnitudes with a final sign correction.
//
// state | meaning
// IDLE  | waiting for a request, req_ready high unless flushed
// BUSY  | one multiply/divide iteration per cycle, counter 31 -> 0
// DONE  | result held on resp_* until resp_ready or flush
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic [XLEN-1:0]  req_a,
  input  logic [XLEN-1:0]  req_b,
  input  logic [TAG_W-1:0] req_tag,
  input  logic             flush,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [XLEN-1:0]  resp_result,
  output logic [TAG_W-1:0] resp_tag,
  output logic             busy
);

  state_e              state_q, state_d;
  muldiv_op_e          op_q, op_d;
  logic [TAG_W-1:0]    tag_q, tag_d;
  logic                neg_q, neg_d;
  logic [4:0]          cnt_q, cnt_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic [XLEN-1:0]     opnd_q, opnd_d;
  logic [XLEN-1:0]     result_q, result_d;
  logic                resp_valid_q, resp_valid_d;

  // Request decode
  muldiv_op_e          in_op;
  logic                a_signed, b_signed, a_neg, b_neg;
  logic [XLEN-1:0]     a_mag, b_mag;
  logic                div_zero, div_ovf;

  // Datapath step
  logic [XLEN:0]       mul_sum;
  logic [2*XLEN-1:0]   mul_next;
  logic [XLEN:0]       div_shift, div_diff;
  logic [2*XLEN-1:0]   div_next;
  logic [2*XLEN-1:0]   step_next;
  logic [2*XLEN-1:0]   prod_s;
  logic [XLEN-1:0]     div_val;
  logic [XLEN-1:0]     final_res;

  assign req_ready   = (state_q == IDLE) && !flush;
  assign busy        = (state_q != IDLE);
  assign resp_valid  = resp_valid_q;
  assign resp_result = result_q;
  assign resp_tag    = tag_q;

  always_comb begin
    in_op    = muldiv_op_e'(req_op);
    a_signed = (in_op == MUL) || (in_op == MULH) || (in_op == MULHSU) ||
               (in_op == DIV) || (in_op == REM);
    b_signed = (in_op == MUL) || (in_op == MULH) || (in_op == DIV) || (in_op == REM);
    a_neg    = a_signed && req_a[XLEN-1];
    b_neg    = b_signed && req_b[XLEN-1];
    a_mag    = a_neg ? (~req_a + 1'b1) : req_a;
    b_mag    = b_neg ? (~req_b + 1'b1) : req_b;
    div_zero = req_op[2] && (req_b == '0);
    div_ovf  = ((in_op == DIV) || (in_op == REM)) &&
               (req_a == INT_MIN) && (req_b == DIV_ZERO_Q);
  end

  // Multiply keeps {accumulator, multiplier} in acc_q; divide keeps {remainder, quotient}.
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    mul_next  = {mul_sum, acc_q[XLEN-1:1]};
    div_shift = acc_q[2*XLEN-1:XLEN-1];
    div_diff  = div_shift - {1'b0, opnd_q};
    div_next  = div_diff[XLEN] ? {div_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                               : {div_diff[XLEN-1:0],  acc_q[XLEN-2:0], 1'b1};
    step_next = op_q[2] ? div_next : mul_next;
    prod_s    = neg_q ? (~mul_next + 1'b1) : mul_next;
    div_val   = op_q[1] ? div_next[2*XLEN-1:XLEN] : div_next[XLEN-1:0];
    if (!op_q[2]) begin
      final_res = (op_q == MUL) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
    end else begin
      final_res = neg_q ? (~div_val + 1'b1) : div_val;
    end
  end

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    tag_d        = tag_q;
    neg_d        = neg_q;
    cnt_d        = cnt_q;
    acc_d        = acc_q;
    opnd_d       = opnd_q;
    result_d     = result_q;
    resp_valid_d = resp_valid_q;

    case (state_q)
      IDLE: begin
        if (req_valid && req_ready) begin
          op_d  = in_op;
          tag_d = req_tag;
          if (!req_op[2]) begin
            neg_d  = a_neg ^ b_neg;
            acc_d  = {{XLEN{1'b0}}, b_mag};
            opnd_d = a_mag;
          end else begin
            neg_d  = req_op[1] ? a_neg : (a_neg ^ b_neg);
            acc_d  = {{XLEN{1'b0}}, a_mag};
            opnd_d = b_mag;
          end
          if (div_zero) begin
            result_d     = req_op[1] ? req_a : DIV_ZERO_Q;
            state_d      = DONE;
            resp_valid_d = 1'b1;
          end else if (div_ovf) begin
            result_d     = req_op[1] ? '0 : INT_MIN;
            state_d      = DONE;
            resp_valid_d = 1'b1;
          end else begin
            state_d = BUSY;
            cnt_d   = 5'd31;
          end
        end
      end
      BUSY: begin
        acc_d = step_next;
        if (cnt_q == 5'd0) begin
          result_d     = final_res;
          state_d      = DONE;
          resp_valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 5'd1;
        end
      end
      DONE: begin
        if (resp_ready) begin
          state_d      = IDLE;
          resp_valid_d = 1'b0;
        end
      end
      default: begin
        state_d      = IDLE;
        resp_valid_d = 1'b0;
      end
    endcase

    // flush outranks both the iteration and the response handshake
    if (flush && (state_q != IDLE)) begin
      state_d      = IDLE;
      resp_valid_d = 1'b0;
      cnt_d        = 5'd0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      op_q         <= MUL;
      tag_q        <= '0;
      neg_q        <= 1'b0;
      cnt_q        <= 5'd0;
      acc_q        <= '0;
      opnd_q       <= '0;
      result_q     <= '0;
      resp_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      tag_q        <= tag_d;
      neg_q        <= neg_d;
      cnt_q        <= cnt_d;
      acc_q        <= acc_d;
      opnd_q       <= opnd_d;
      result_q     <= result_d;
      resp_valid_q <= resp_valid_d;
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq: vector table plus backpressure, flush and reset sequences.
module tb_muldiv_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_op = 3'd0;
  logic [31:0] req_a = '0;
  logic [31:0] req_b = '0;
  logic [4:0]  req_tag = '0;
  logic        flush = 1'b0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_result;
  logic [4:0]  resp_tag;
  logic        busy;

  int errors = 0;
  int checks = 0;

  localparam logic [2:0] OP_MUL = 3'd0, OP_MULH = 3'd1, OP_MULHSU = 3'd2, OP_MULHU = 3'd3;
  localparam logic [2:0] OP_DIV = 3'd4, OP_DIVU = 3'd5, OP_REM = 3'd6, OP_REMU = 3'd7;

  muldiv_seq #(.XLEN(32), .TAG_W(5)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
    .flush(flush),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_result(resp_result), .resp_tag(resp_tag),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  tag;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                              input logic [4:0] tag, input logic [31:0] exp, input int lat);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.tag = tag; v.exp = exp; v.lat = lat;
    return v;
  endfunction

  // Present a request at a negedge; it is accepted on the following posedge.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] tag);
    @(negedge clk);
    check("req_ready_before_issue", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b; req_tag = tag;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  // Latency in cycles after the accept edge until resp_valid is seen (bounded).
  task automatic wait_resp(output int lat);
    lat = 1;
    @(negedge clk);
    while (!resp_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic release_resp();
    resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;
    @(negedge clk);
    check("idle_after_handshake", {30'd0, busy, resp_valid}, 32'd0);
  endtask

  initial begin
    int lat;
    logic [31:0] held;

    vecs.push_back(mk(OP_MUL,    32'd7,          32'hFFFF_FFFD, 5'd3,  32'hFFFF_FFEB, 33));
    vecs.push_back(mk(OP_MULH,   32'h8000_0000, 32'h8000_0000, 5'd4,  32'h4000_0000, 33));
    vecs.push_back(mk(OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5,  32'hFFFF_FFFE, 33));
    vecs.push_back(mk(OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6,  32'hFFFF_FFFF, 33));
    vecs.push_back(mk(OP_MUL,    32'h1234_5678, 32'h10,        5'd7,  32'h2345_6780, 33));
    vecs.push_back(mk(OP_MULH,   32'hFFFF_FFFF, 32'd1,         5'd8,  32'hFFFF_FFFF, 33));
    vecs.push_back(mk(OP_MULHU,  32'h8000_0000, 32'd2,         5'd9,  32'h0000_0001, 33));
    vecs.push_back(mk(OP_DIV,    32'hFFFF_FFF9, 32'd2,         5'd10, 32'hFFFF_FFFD, 33));
    vecs.push_back(mk(OP_REM,    32'hFFFF_FFF9, 32'd2,         5'd11, 32'hFFFF_FFFF, 33));
    vecs.push_back(mk(OP_DIVU,   32'd100,       32'd7,         5'd12, 32'd14,        33));
    vecs.push_back(mk(OP_REMU,   32'd100,       32'd7,         5'd13, 32'd2,         33));
    vecs.push_back(mk(OP_DIV,    32'd7,         32'hFFFF_FFFE, 5'd14, 32'hFFFF_FFFD, 33));
    vecs.push_back(mk(OP_REM,    32'd7,         32'hFFFF_FFFE, 5'd15, 32'd1,         33));
    vecs.push_back(mk(OP_DIVU,   32'd5,         32'd0,         5'd16, 32'hFFFF_FFFF, 1));
    vecs.push_back(mk(OP_REMU,   32'd5,         32'd0,         5'd17, 32'd5,         1));
    vecs.push_back(mk(OP_DIV,    32'd5,         32'd0,         5'd18, 32'hFFFF_FFFF, 1));
    vecs.push_back(mk(OP_REM,    32'hFFFF_FFFB, 32'd0,         5'd19, 32'hFFFF_FFFB, 1));
    vecs.push_back(mk(OP_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 5'd20, 32'h8000_0000, 1));
    vecs.push_back(mk(OP_REM,    32'h8000_0000, 32'hFFFF_FFFF, 5'd21, 32'd0,         1));

    #12;
    check("reset_resp_valid",  {31'd0, resp_valid}, 32'd0);
    check("reset_busy",        {31'd0, busy},       32'd0);
    check("reset_req_ready",   {31'd0, req_ready},  32'd1);
    check("reset_resp_result", resp_result,         32'd0);
    check("reset_resp_tag",    {27'd0, resp_tag},   32'd0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].tag);
      wait_resp(lat);
      check($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
      check($sformatf("vec%0d_result", i), resp_result, vecs[i].exp);
      check($sformatf("vec%0d_tag", i), {27'd0, resp_tag}, {27'd0, vecs[i].tag});
      release_resp();
    end

    // Backpressure: result held, new requests ignored while DONE.
    issue(OP_DIVU, 32'd100, 32'd7, 5'd9);
    wait_resp(lat);
    check("bp_latency", lat, 33);
    held = resp_result;
    req_valid = 1'b1; req_op = OP_MUL; req_a = 32'd3; req_b = 32'd3; req_tag = 5'd1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("bp_result_stable", resp_result, 32'd14);
      check("bp_tag_stable", {27'd0, resp_tag}, 32'd9);
      check("bp_req_ready_low", {31'd0, req_ready}, 32'd0);
      check("bp_valid_high", {31'd0, resp_valid}, 32'd1);
    end
    req_valid = 1'b0;
    check("bp_held_value", held, 32'd14);
    release_resp();
    @(negedge clk);
    check("bp_no_queued_req", {31'd0, busy}, 32'd0);

    // Flush at T+10 of a DIV, then a new request completes normally.
    issue(OP_DIV, 32'hFFFF_FFF9, 32'd2, 5'd2);
    repeat (10) @(negedge clk);
    check("flush_busy_before", {31'd0, busy}, 32'd1);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    check("flush_idle", {30'd0, busy, resp_valid}, 32'd0);
    issue(OP_REM, 32'd100, 32'hFFFF_FFF9, 5'd22);
    wait_resp(lat);
    check("after_flush_latency", lat, 33);
    check("after_flush_result", resp_result, 32'd2);
    check("after_flush_tag", {27'd0, resp_tag}, 32'd22);
    release_resp();

    // flush masks req_ready in IDLE.
    @(negedge clk);
    flush = 1'b1; req_valid = 1'b1; req_op = OP_DIVU; req_a = 32'd9; req_b = 32'd3;
    #1 check("flush_masks_ready", {31'd0, req_ready}, 32'd0);
    @(posedge clk);
    #1 begin flush = 1'b0; req_valid = 1'b0; end
    @(negedge clk);
    check("flush_idle_no_accept", {31'd0, busy}, 32'd0);

    // flush dominates resp_ready in DONE.
    issue(OP_DIVU, 32'd5, 32'd0, 5'd23);
    wait_resp(lat);
    check("done_flush_latency", lat, 1);
    flush = 1'b1; resp_ready = 1'b1;
    @(posedge clk);
    #1 begin flush = 1'b0; resp_ready = 1'b0; end
    @(negedge clk);
    check("done_flush_idle", {30'd0, busy, resp_valid}, 32'd0);

    // Async reset mid-BUSY.
    issue(OP_MUL, 32'd7, 32'd9, 5'd27);
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_resp_valid",  {31'd0, resp_valid}, 32'd0);
    check("arst_busy",        {31'd0, busy},       32'd0);
    check("arst_req_ready",   {31'd0, req_ready},  32'd1);
    check("arst_resp_result", resp_result,         32'd0);
    check("arst_resp_tag",    {27'd0, resp_tag},   32'd0);
    @(negedge clk);
    rst = 1'b0;
    issue(OP_MUL, 32'd7, 32'd9, 5'd28);
    wait_resp(lat);
    check("post_rst_latency", lat, 33);
    check("post_rst_result", resp_result, 32'd63);
    release_resp();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
